mem_port_arbiter: RTL and testbench

Shares the single-ported unified 256-byte memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Each cycle it grants at most one requester and drives the memory's read, write, func3, address and write-data lines. Read responses are registered one cycle after grant. A bounded-starvation counter gives data accesses priority while guaranteeing fetch progress. The losing requester is told to stall; the fetch side receives the NOP encoding whenever it has no valid instruction.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_starve_counter.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared constants and types for the unified-memory port arbiter:
//   NOP_INST   - instruction word handed to fetch when nothing valid is there
//   F3_WORD    - func3 code for a 32-bit word access (also the idle default)
//   owner_e    - who owned the memory in the previous cycle
//   cnt_width  - width of a counter that must hold 0..max (never below 1)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0033;
  localparam logic [2:0]  F3_WORD  = 3'b010;

  typedef enum logic [1:0] {
    OWN_IDLE    = 2'd0,
    OWN_FETCH   = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_DATA_WR = 2'd3
  } owner_e;

  // A counter for max=0 still needs one physical bit.
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// Saturating count of consecutive data grants taken while fetch was waiting.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the count
//   inc  - data won while fetch was requesting
//   clr  - fetch was granted or fetch was not requesting (wins over inc)
//   sat  - count has reached STARVE_MAX; fetch must win the next tie
// -----------------------------------------------------------------------------
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int          CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] streak_q;
  logic [CNT_W-1:0] streak_d;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    streak_d = streak_q;
    if (clr) begin
      streak_d = '0;
    end else if (inc && (streak_q != CNT_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // With STARVE_MAX=0 the count never leaves zero, so sat is constantly high
  // and fetch wins every tie.
  assign sat = (streak_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// data port. At most one requester is granted per cycle; data wins ties until
// it has won STARVE_MAX ties in a row, then fetch is let through once.
// Read responses are registered and appear the cycle after the grant.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   if_req/if_addr                 - fetch request and address
//   if_gnt/if_rdata/if_rvalid      - fetch grant, instruction, response pulse
//   d_req/d_we/d_func3/d_addr/d_wdata - data request and command
//   d_gnt/d_rdata/d_rvalid         - data grant, load data, completion pulse
//   stall_if/stall_mem             - requester asked but was not granted
//   mem_rd/mem_wr/mem_func3/mem_addr/mem_wdata - memory command
//   mem_rdata                      - combinational memory read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  // stalls
  output logic              stall_if,
  output logic              stall_mem,
  // memory side
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              sat;
  owner_e            owner_q;
  owner_e            owner_d;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // ---------------------------------------------------------------------------
  // Grant: data wins a tie unless fetch has waited STARVE_MAX ties already.
  // Reset suppresses both grants so no write can land during reset.
  // ---------------------------------------------------------------------------
  assign d_gnt     = ~rst & d_req  & ~(if_req & sat);
  assign if_gnt    = ~rst & if_req & (~d_req | sat);
  assign stall_if  = if_req & ~if_gnt;
  assign stall_mem = d_req  & ~d_gnt;

  // Count only ties lost by fetch; a fetch grant or an idle fetch side
  // restarts the count.
  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk (clk),
    .rst (rst),
    .inc (d_gnt & if_req),
    .clr (if_gnt | ~if_req),
    .sat (sat)
  );

  // ---------------------------------------------------------------------------
  // Memory command mux and next owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_func3 = F3_WORD;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_IDLE;
    if (if_gnt) begin
      mem_rd   = 1'b1;
      mem_addr = if_addr;
      owner_d  = OWN_FETCH;
    end else if (d_gnt) begin
      mem_rd    = ~d_we;
      mem_wr    = d_we;
      mem_func3 = d_func3;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      owner_d   = d_we ? OWN_DATA_WR : OWN_DATA_RD;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner register and response capture. The owner recorded here is the
  // grant of the cycle just ended, which is what the rvalid pulses report.
  // ---------------------------------------------------------------------------
  // NOTE: the read-data registers are reset because their reset value is
  // architecturally visible (fetch must see a NOP before its first response).
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_IDLE;
      if_rdata_q <= DATA_W'(NOP_INST);
      d_rdata_q  <= '0;
    end else begin
      owner_q <= owner_d;
      case (owner_d)
        OWN_FETCH:   if_rdata_q <= mem_rdata;
        OWN_DATA_RD: d_rdata_q  <= mem_rdata;
        default:     ;  // stores and idle cycles leave both read registers alone
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_rvalid = (owner_q == OWN_FETCH);
  assign d_rvalid  = (owner_q == OWN_DATA_RD) || (owner_q == OWN_DATA_WR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiters (STARVE_MAX=3 and STARVE_MAX=0) see identical requests, each
// with its own byte memory. A reference model per instance predicts grants,
// memory commands and responses from the arbitration rules and a model copy
// of memory; directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt_w    [2];
  logic [31:0] if_rdata_w  [2];
  logic        if_rvalid_w [2];
  logic        d_gnt_w     [2];
  logic [31:0] d_rdata_w   [2];
  logic        d_rvalid_w  [2];
  logic        stall_if_w  [2];
  logic        stall_mem_w [2];
  logic        mem_rd_w    [2];
  logic        mem_wr_w    [2];
  logic [2:0]  mem_func3_w [2];
  logic [7:0]  mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] mem_rdata_w [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) + 11);
  endfunction

  // ---------------------------------------------------------------------------
  // DUT instances with their own memories
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];

    assign mem_rdata_w[g] = {mem[8'(mem_addr_w[g] + 8'd3)], mem[8'(mem_addr_w[g] + 8'd2)],
                             mem[8'(mem_addr_w[g] + 8'd1)], mem[mem_addr_w[g]]};

    always @(posedge clk) begin
      if (mem_init) begin
        for (int a = 0; a < 256; a++) mem[a] <= init_byte(a);
      end else if (mem_wr_w[g]) begin
        mem[mem_addr_w[g]] <= mem_wdata_w[g][7:0];
        if (mem_func3_w[g][1:0] != 2'b00) mem[8'(mem_addr_w[g] + 8'd1)] <= mem_wdata_w[g][15:8];
        if (mem_func3_w[g][1] == 1'b1) begin
          mem[8'(mem_addr_w[g] + 8'd2)] <= mem_wdata_w[g][23:16];
          mem[8'(mem_addr_w[g] + 8'd3)] <= mem_wdata_w[g][31:24];
        end
      end
    end

    mem_port_arbiter #(
      .ADDR_W     (8),
      .DATA_W     (32),
      .STARVE_MAX ((g == 0) ? 3 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt_w[g]),
      .if_rdata  (if_rdata_w[g]),
      .if_rvalid (if_rvalid_w[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_func3   (d_func3),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_w[g]),
      .d_rdata   (d_rdata_w[g]),
      .d_rvalid  (d_rvalid_w[g]),
      .stall_if  (stall_if_w[g]),
      .stall_mem (stall_mem_w[g]),
      .mem_rd    (mem_rd_w[g]),
      .mem_wr    (mem_wr_w[g]),
      .mem_func3 (mem_func3_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: memory copy, tie-loss count and expected responses
  // ---------------------------------------------------------------------------
  logic [7:0]  mm [2][256];
  int          lost_ties   [2];
  logic [31:0] exp_if_rdata [2];
  logic [31:0] exp_d_rdata  [2];
  logic        exp_if_rvalid[2];
  logic        exp_d_rvalid [2];
  bit          known = 1'b0;
  int          cnt_stall_if [2];
  int          cnt_stall_mem[2];

  function automatic logic [31:0] m_read(input int k, input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {mm[k][a3], mm[k][a2], mm[k][a1], mm[k][a]};
  endfunction

  task automatic m_write(input int k, input logic [7:0] a, input logic [2:0] f3,
                         input logic [31:0] wd);
    int nbytes;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) mm[k][8'(a + 8'(i))] = wd[8*i +: 8];
  endtask

  // Called at the negedge: check the cycle's outputs, then advance the model
  // across the coming posedge.
  task automatic model_cycle(input int k);
    int          starve_max;
    bit          eg_d, eg_i;
    logic [7:0]  e_addr;
    starve_max = (k == 0) ? 3 : 0;
    eg_d = !rst && d_req && (!if_req || (lost_ties[k] < starve_max));
    eg_i = !rst && if_req && !eg_d;
    e_addr = eg_i ? if_addr : (eg_d ? d_addr : 8'h00);

    if (known) begin
      check($sformatf("if_rvalid%0d", k), 32'(if_rvalid_w[k]), 32'(exp_if_rvalid[k]));
      check($sformatf("d_rvalid%0d", k),  32'(d_rvalid_w[k]),  32'(exp_d_rvalid[k]));
      check($sformatf("if_rdata%0d", k),  if_rdata_w[k],       exp_if_rdata[k]);
      check($sformatf("d_rdata%0d", k),   d_rdata_w[k],        exp_d_rdata[k]);
    end
    check($sformatf("if_gnt%0d", k),    32'(if_gnt_w[k]),    32'(eg_i));
    check($sformatf("d_gnt%0d", k),     32'(d_gnt_w[k]),     32'(eg_d));
    check($sformatf("stall_if%0d", k),  32'(stall_if_w[k]),  32'(if_req && !eg_i));
    check($sformatf("stall_mem%0d", k), 32'(stall_mem_w[k]), 32'(d_req && !eg_d));
    check($sformatf("mem_rd%0d", k),    32'(mem_rd_w[k]),    32'(eg_i || (eg_d && !d_we)));
    check($sformatf("mem_wr%0d", k),    32'(mem_wr_w[k]),    32'(eg_d && d_we));
    check($sformatf("mem_addr%0d", k),  32'(mem_addr_w[k]),  32'(e_addr));
    check($sformatf("mem_func3%0d", k), 32'(mem_func3_w[k]), 32'(eg_d ? d_func3 : 3'b010));
    if (!eg_i) check($sformatf("mem_wdata%0d", k), mem_wdata_w[k], eg_d ? d_wdata : 32'h0);
    if (eg_i || eg_d) check($sformatf("mem_rdata%0d", k), mem_rdata_w[k], m_read(k, e_addr));

    if (if_req && !eg_i) cnt_stall_if[k]++;
    if (d_req && !eg_d)  cnt_stall_mem[k]++;

    if (rst) begin
      lost_ties[k]     = 0;
      exp_if_rdata[k]  = NOP_INST;
      exp_d_rdata[k]   = 32'h0;
      exp_if_rvalid[k] = 1'b0;
      exp_d_rvalid[k]  = 1'b0;
    end else begin
      exp_if_rvalid[k] = eg_i;
      exp_d_rvalid[k]  = eg_d;
      if (eg_i) exp_if_rdata[k] = m_read(k, if_addr);
      if (eg_d && !d_we) exp_d_rdata[k] = m_read(k, d_addr);
      if (eg_d && d_we) m_write(k, d_addr, d_func3, d_wdata);
      if (eg_d && if_req) lost_ties[k] = (lost_ties[k] < starve_max) ? lost_ties[k] + 1 : starve_max;
      else lost_ties[k] = 0;
    end
  endtask

  task automatic finish_cycle();
    model_cycle(0);
    model_cycle(1);
    if (rst) known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic set_req(input logic ir, input logic [7:0] ia, input logic dr, input logic we,
                         input logic [2:0] f3, input logic [7:0] da, input logic [31:0] wd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_func3 = f3; d_addr = da; d_wdata = wd;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) mm[k][a] = init_byte(a);
      lost_ties[k] = 0;
      cnt_stall_if[k] = 0;
      cnt_stall_mem[k] = 0;
    end
    rst = 1'b1;
    mem_init = 1'b1;
    set_req(1'b1, 8'h40, 1'b1, 1'b0, 3'b010, 8'h80, 32'h0);

    // Reset with both requests high.
    cycle();
    mem_init = 1'b0;
    cycle();

    // Release: data wins first, then D,D,D,I,D,D,D,I for STARVE_MAX=3.
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin cnt_stall_if[k] = 0; cnt_stall_mem[k] = 0; end
    @(negedge clk);
    check("first_dgnt_after_rst", 32'(d_gnt_w[0]), 32'd1);
    check("rst_if_rdata_nop", if_rdata_w[0], 32'h0000_0033);
    finish_cycle();
    for (int i = 1; i < 8; i++) begin
      if_addr = 8'(8'h40 + 8'(4 * i));
      d_addr  = 8'(8'h80 + 8'(4 * i));
      cycle();
    end
    check("stall_if_count_sm3", 32'(cnt_stall_if[0]), 32'd6);
    check("stall_mem_count_sm0", 32'(cnt_stall_mem[1]), 32'd8);
    check("stall_if_count_sm0", 32'(cnt_stall_if[1]), 32'd0);

    // Fetch only at 0, 4, 8.
    set_req(1'b1, 8'h00, 1'b0, 1'b0, 3'b010, 8'h00, 32'h0);
    cycle();
    if_addr = 8'h04; cycle();
    if_addr = 8'h08; cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_word_at_8", if_rdata_w[0],
          {init_byte(11), init_byte(10), init_byte(9), init_byte(8)});
    finish_cycle();

    // Store then load at 8'h10.
    set_req(1'b0, 8'h00, 1'b1, 1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    check("store_mem_wr", 32'(mem_wr_w[0]), 32'd1);
    finish_cycle();
    set_req(1'b0, 8'h00, 1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("load_after_store", d_rdata_w[0], 32'hDEAD_BEEF);
    finish_cycle();

    // Reset during a store grant: nothing written, no completion.
    set_req(1'b1, 8'h20, 1'b1, 1'b1, 3'b010, 8'h10, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    check("rst_store_mem_wr", 32'(mem_wr_w[0]), 32'd0);
    finish_cycle();
    rst = 1'b0;
    set_req(1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 8'h00, 32'h0);
    @(negedge clk);
    check("rst_store_no_rvalid", 32'(d_rvalid_w[0]), 32'd0);
    check("rst_store_if_nop", if_rdata_w[0], 32'h0000_0033);
    finish_cycle();
    set_req(1'b0, 8'h00, 1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("mem_kept_after_rst_store", d_rdata_w[0], 32'hDEAD_BEEF);
    finish_cycle();

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_req(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 2)), 8'($urandom), $urandom);
      cycle();
    end
    rst = 1'b0;
    set_req(1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 8'h00, 32'h0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
